// File: rtl/rv_pkg.sv
// Shared RV32 register-file constants: data width, architectural register
// numbers, stack-pointer reset value and the register address type.
package rv_pkg;

   localparam int XLEN        = 32;
   localparam int NREGS_RV32I = 32;
   localparam int AW          = $clog2(NREGS_RV32I);

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 2;

   localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFFFFF0;

   typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. Flush beats issue,
// issue beats writeback clear, and x0 is never busy.
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int NWR   = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic              flush,
   output logic [NREGS-1:0]  busy
);
   import rv_pkg::*;

   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] busy_q;

   // NOTE: every bit of busy_d gets a default before any conditional update,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w] && wr_addr[w*AW +: AW] != AW'(REG_ZERO))
            busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
      // A younger writer issued this cycle keeps the bit set over a writeback.
      if (iss_valid && iss_rd != AW'(REG_ZERO))
         busy_d[iss_rd] = 1'b1;
      if (flush)
         busy_d = '0;
      busy_d[REG_ZERO] = 1'b0;
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
   parameter int          XLEN    = rv_pkg::XLEN,
   parameter int          NREGS   = 32,
   parameter int          NRD     = 2,
   parameter int          NWR     = 1,
   parameter logic [31:0] SP_INIT = rv_pkg::SP_INIT_DEFAULT,
   localparam int         AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic                stall
);
   import rv_pkg::*;

   localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

   logic [XLEN-1:0]  regs_d [NREGS];
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy;

   logic [AW-1:0]    ra;
   logic [XLEN-1:0]  rdat;
   logic             rbusy;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .busy      (busy)
   );

   // Later ports overwrite earlier ones, so the highest-indexed writer wins.
   always_comb begin
      regs_d = regs_q;
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w] && wr_addr[w*AW +: AW] != AW'(REG_ZERO))
            regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
   end

   // NOTE: the array is built from flops and carries a reset, because x2 must
   // come up holding the stack pointer and a reset must discard all contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= (i == REG_SP) ? SP_RESET : '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rdat    = '0;
      rbusy   = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         ra    = rd_addr[k*AW +: AW];
         rdat  = '0;
         rbusy = 1'b0;
         if (ra != AW'(REG_ZERO)) begin
            rdat  = regs_q[ra];
            rbusy = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
                  rdat  = wr_data[w*XLEN +: XLEN];
                  rbusy = rbusy & iss_valid & (iss_rd == ra);
               end
            end
`endif
         end
         if (rst_n) begin
            rd_data[k*XLEN +: XLEN] = rdat;
            rd_busy[k]              = rbusy;
         end
      end
   end

   assign stall = |rd_busy;

endmodule
